// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states
//   rr_width()  : bit width of the round-robin pointer for n requesters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Pointer width; never below one bit so a vector can always be declared.
  function automatic int unsigned rr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector, one bit per requester
//   i_ptr    : index of the highest-priority requester
//   o_pick_c : one-hot first set request at or after i_ptr, wrapping
//   o_any_c  : at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = rr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick_c,
  output logic               o_any_c
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_dbl_rot;
  logic [2*NUM_REQ-1:0] w_oh_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_oh;

  // Rotate so i_ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_dbl     = {i_req, i_req};
    w_dbl_rot = w_dbl >> i_ptr;
    w_rot     = w_dbl_rot[NUM_REQ-1:0];
    w_oh      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_oh    = '0;
        w_oh[i] = 1'b1;
      end
    end
    w_oh_dbl = {{NUM_REQ{1'b0}}, w_oh} << i_ptr;
    o_pick_c = w_oh_dbl[NUM_REQ-1:0] | w_oh_dbl[2*NUM_REQ-1:NUM_REQ];
    o_any_c  = |i_req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
//   W_CLK, W_rst_n : write-domain clock, async active-low reset
//   Req_Valid/Req_Data/Req_Ready : per-requester valid/ready word interface
//   Full           : FIFO full, stalls the granted requester
//   W_inc, W_Data  : FIFO write strobe and data (same cycle as handshake)
//   Grant          : registered one-hot owner, zero when idle
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          W_CLK,
  input  logic                          W_rst_n,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ready,
  input  logic                          Full,
  output logic                          W_inc,
  output logic [DATA_WIDTH-1:0]         W_Data,
  output logic [NUM_REQ-1:0]            Grant
);

  localparam int unsigned PTR_W = rr_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_burst_cnt;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_in_grant;
  logic               w_gnt_valid;
  logic               w_xfer;
  logic               w_last;
  logic               w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req    (Req_Valid),
    .i_ptr    (r_rr_ptr),
    .o_pick_c (w_pick),
    .o_any_c  (w_any)
  );

  // Grant index and write-data mux; slice 0 is driven while idle.
  always_comb begin
    w_gnt_idx = '0;
    W_Data    = Req_Data[0 +: DATA_WIDTH];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gnt_idx = PTR_W'(i);
        W_Data    = Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake, burst termination and release decode.
  always_comb begin
    w_in_grant  = (r_state == GRANT);
    w_gnt_valid = |(Req_Valid & r_grant);
    w_xfer      = w_in_grant & w_gnt_valid & ~Full;
    w_last      = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    // Dropped valid releases even under Full; the unused allowance is lost.
    w_release   = w_in_grant & ((w_xfer & w_last) | ~w_gnt_valid);
    w_next_ptr  = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    Req_Ready   = (w_in_grant & ~Full) ? r_grant : '0;
    W_inc       = w_xfer;
  end

  assign Grant = r_grant;

  // Arbiter FSM with grant, pointer and burst counter.
  always_ff @(posedge W_CLK or negedge W_rst_n) begin
    if (!W_rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_grant     <= '0;
            r_rr_ptr    <= w_next_ptr;
            r_burst_cnt <= '0;
            r_state     <= IDLE;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Requester i offers words 0x10*(i+1)+n, advancing n on each handshake.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          W_CLK;
  logic          W_rst_n;
  logic [NR-1:0] Req_Valid;
  logic [NR*DW-1:0] Req_Data;
  logic [NR-1:0] Req_Ready;
  logic          Full;
  logic          W_inc;
  logic [DW-1:0] W_Data;
  logic [NR-1:0] Grant;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [7:0]    cnt[NR];
  int            n_checks;
  int            n_fail;
  logic          s_winc;
  logic [NR-1:0] s_gnt;
  logic [NR-1:0] s_ready;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .W_CLK     (W_CLK),
    .W_rst_n   (W_rst_n),
    .Req_Valid (Req_Valid),
    .Req_Data  (Req_Data),
    .Req_Ready (Req_Ready),
    .Full      (Full),
    .W_inc     (W_inc),
    .W_Data    (W_Data),
    .Grant     (Grant)
  );

  initial W_CLK = 1'b0;
  always #5 W_CLK = ~W_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic refresh();
    for (int i = 0; i < NR; i++) Req_Data[i*DW +: DW] = 8'((i + 1) * 16) + cnt[i];
  endtask

  task automatic push(input logic [NR-1:0] g, input logic [7:0] d0, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{gnt: g, data: d0 + 8'(k)});
  endtask

  // One clock: sample at negedge, score any write, advance handshaken requesters.
  task automatic cycle();
    exp_t          e;
    logic [NR-1:0] hs;
    @(negedge W_CLK);
    s_winc  = W_inc;
    s_gnt   = Grant;
    s_ready = Req_Ready;
    hs      = Req_Valid & Req_Ready;
    if (Full === 1'b1) begin
      n_checks++;
      if (W_inc !== 1'b0) begin
        n_fail++;
        $display("FAIL write_while_full: W_inc=%b required 0", W_inc);
      end
    end
    if (W_inc === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: data=%h grant=%b, nothing expected", W_Data, Grant);
      end else begin
        e = sb.pop_front();
        if (W_Data !== e.data || Grant !== e.gnt) begin
          n_fail++;
          $display("FAIL write_data: got data=%h grant=%b required data=%h grant=%b",
                   W_Data, Grant, e.data, e.gnt);
        end
      end
    end
    @(posedge W_CLK);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) cnt[i] = cnt[i] + 8'd1;
    refresh();
  endtask

  task automatic drain(input int n, input string name);
    repeat (n) cycle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_words: %0d words unwritten, required 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    W_rst_n   = 1'b0;
    Req_Valid = '0;
    Full      = 1'b0;
    for (int i = 0; i < NR; i++) cnt[i] = 8'd0;
    refresh();
    sb.delete();
    repeat (2) @(posedge W_CLK);
    #1;
    W_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    W_rst_n   = 1'b0;
    Full      = 1'b0;
    Req_Valid = 4'b1111;
    for (int i = 0; i < NR; i++) cnt[i] = 8'd0;
    refresh();
    repeat (2) @(negedge W_CLK);
    n_checks += 3;
    if (Grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b required 0000", Grant); end
    if (W_inc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b required 0", W_inc); end
    if (Req_Ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b required 0000", Req_Ready); end
  endtask

  task automatic test_single();
    logic exp;
    do_reset();
    push(4'b0001, 8'h10, 8);
    Req_Valid = 4'b0001;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      exp = (j >= 2) && (j != 6);
      n_checks++;
      if (s_winc !== exp) begin n_fail++; $display("FAIL single_winc cyc%0d: got %b required %b", j, s_winc, exp); end
      if (j == 2) begin
        n_checks++;
        if (s_gnt !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b required 0001", s_gnt); end
      end
      if (j == 6) begin
        n_checks++;
        if (s_gnt !== 4'b0000) begin n_fail++; $display("FAIL single_bubble: got %b required 0000", s_gnt); end
      end
    end
    Req_Valid = '0;
    drain(3, "single");
  endtask

  task automatic test_all_four();
    logic exp;
    int   pulses;
    do_reset();
    push(4'b0001, 8'h10, 4);
    push(4'b0010, 8'h20, 4);
    push(4'b0100, 8'h30, 4);
    push(4'b1000, 8'h40, 4);
    push(4'b0001, 8'h14, 4);
    Req_Valid = 4'b1111;
    pulses = 0;
    for (int j = 1; j <= 25; j++) begin
      cycle();
      exp = (j >= 2) && (((j - 2) % 5) != 4);
      if (s_winc === 1'b1) pulses++;
      n_checks++;
      if (s_winc !== exp) begin n_fail++; $display("FAIL all4_winc cyc%0d: got %b required %b", j, s_winc, exp); end
    end
    n_checks++;
    if (pulses != 20) begin n_fail++; $display("FAIL all4_pulses: got %0d required 20", pulses); end
    Req_Valid = '0;
    drain(3, "all4");
  endtask

  task automatic test_full_stall();
    do_reset();
    push(4'b0001, 8'h10, 4);
    Req_Valid = 4'b0001;
    repeat (3) cycle();
    Full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      n_checks += 4;
      if (s_winc !== 1'b0) begin n_fail++; $display("FAIL stall_winc: got %b required 0", s_winc); end
      if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready: got %b required 0000", s_ready); end
      if (s_gnt !== 4'b0001) begin n_fail++; $display("FAIL stall_grant: got %b required 0001", s_gnt); end
      if (dut.r_burst_cnt !== 3'd2) begin n_fail++; $display("FAIL stall_burst_cnt: got %0d required 2", dut.r_burst_cnt); end
    end
    Full = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      n_checks++;
      if (s_winc !== (j < 2)) begin n_fail++; $display("FAIL resume_winc %0d: got %b required %b", j, s_winc, (j < 2)); end
    end
    Req_Valid = '0;
    drain(3, "stall");
  endtask

  task automatic test_drop_valid();
    do_reset();
    push(4'b0100, 8'h30, 1);
    push(4'b1000, 8'h40, 4);
    Req_Valid = 4'b0100;
    repeat (2) cycle();
    Req_Valid = 4'b1001;
    cycle();
    n_checks += 2;
    if (s_winc !== 1'b0) begin n_fail++; $display("FAIL drop_winc: got %b required 0", s_winc); end
    if (s_gnt !== 4'b0100) begin n_fail++; $display("FAIL drop_grant_held: got %b required 0100", s_gnt); end
    cycle();
    n_checks += 2;
    if (s_gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_release: got %b required 0000", s_gnt); end
    if (dut.r_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL drop_rr_ptr: got %0d required 3", dut.r_rr_ptr); end
    cycle();
    n_checks += 2;
    if (s_gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_next_grant: got %b required 1000", s_gnt); end
    if (s_winc !== 1'b1) begin n_fail++; $display("FAIL drop_next_winc: got %b required 1", s_winc); end
    repeat (3) cycle();
    Req_Valid = '0;
    drain(3, "drop");
  endtask

  task automatic test_drop_full();
    do_reset();
    push(4'b0001, 8'h10, 1);
    Req_Valid = 4'b0001;
    repeat (2) cycle();
    Full = 1'b1;
    cycle();
    Req_Valid = 4'b0000;
    cycle();
    n_checks += 2;
    if (s_winc !== 1'b0) begin n_fail++; $display("FAIL dropfull_winc: got %b required 0", s_winc); end
    if (s_gnt !== 4'b0001) begin n_fail++; $display("FAIL dropfull_grant: got %b required 0001", s_gnt); end
    cycle();
    n_checks += 2;
    if (s_gnt !== 4'b0000) begin n_fail++; $display("FAIL dropfull_release: got %b required 0000", s_gnt); end
    if (s_winc !== 1'b0) begin n_fail++; $display("FAIL dropfull_release_winc: got %b required 0", s_winc); end
    Full = 1'b0;
    drain(2, "dropfull");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(4'b0100, 8'h30, 4);
    push(4'b1000, 8'h40, 2);
    Req_Valid = 4'b1100;
    repeat (8) cycle();
    #2;
    W_rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (Grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b required 0000", Grant); end
    if (W_inc !== 1'b0) begin n_fail++; $display("FAIL rstmid_winc: got %b required 0", W_inc); end
    if (Req_Ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready: got %b required 0000", Req_Ready); end
    if (sb.size() != 0) begin n_fail++; $display("FAIL rstmid_words: %0d unwritten required 0", sb.size()); end
    @(posedge W_CLK);
    #1;
    n_checks++;
    if (W_inc !== 1'b0) begin n_fail++; $display("FAIL rstmid_edge_winc: got %b required 0", W_inc); end
    W_rst_n   = 1'b1;
    Req_Valid = 4'b1110;
    push(4'b0010, 8'h20, 1);
    cycle();
    n_checks++;
    if (s_gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_idle: got %b required 0000", s_gnt); end
    cycle();
    n_checks++;
    if (s_gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_first_grant: got %b required 0010", s_gnt); end
    Req_Valid = '0;
    drain(3, "rstmid");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    W_rst_n   = 1'b0;
    Req_Valid = '0;
    Req_Data  = '0;
    Full      = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_full_stall();
    test_drop_valid();
    test_drop_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
